msk_and_hpc3_seq: RTL and testbench

Issue controller for a bank of `W` parallel masked HPC3 AND gadgets (cross-domain form, inner term enabled), with `d` shares each. It sits between a masked-operand producer, the PRNG randomness port and a downstream consumer. It uses valid/ready handshakes to sequence the gadgets' two-cycle evaluation, and it makes sure every evaluation consumes exactly one fresh randomness word. The gadget bank's internal registers run freely with no enable, so this block must never issue work that it cannot retire.

---
 rtl/msk_and_hpc3_seq.sv | 105 ++++++++++
 tb/tb_msk_and_hpc3_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/msk_and_hpc3_seq.sv
// Issue controller for a bank of W masked HPC3 AND gadgets with d shares each.
// Optional idle zeroization of the gadget inputs: define MSK_SEQ_ZEROIZE_EN.
module msk_and_hpc3_seq #(
  parameter  int d  = 2,
  parameter  int W  = 8,
  localparam int RW = W * d * (d - 1)
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W*d-1:0]  in_a,
  input  logic [W*d-1:0]  in_b,
  input  logic            rnd_valid,
  output logic            rnd_ready,
  input  logic [RW-1:0]   rnd,
  output logic [W*d-1:0]  g_ina,
  output logic [W*d-1:0]  g_inb,
  output logic [RW-1:0]   g_rnd,
  output logic [W*d-1:0]  g_ina_prev,
  input  logic [W*d-1:0]  g_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W*d-1:0]  out_data,
  output logic            busy
);

  localparam int DW = W * d;

  logic          s1_valid_q;
  logic [1:0]    count_q, count_d;
  logic          wr_ptr_q, rd_ptr_q;
  logic [DW-1:0] a_prev_q;
  logic [DW-1:0] fifo_q [2];

  logic          push, pop, can_issue, fire;
  logic [2:0]    occupancy;

  assign pop       = (count_q != 2'd0) & out_ready;
  assign push      = s1_valid_q;
  assign occupancy = {1'b0, count_q} + {2'b00, s1_valid_q} - {2'b00, pop};
  // The gadget bank has no stall, so issue only when the result is sure to find a
  // FIFO slot; nrst gating keeps both readies low while in reset.
  assign can_issue = nrst & (occupancy < 3'd2);

  assign fire      = in_valid & rnd_valid & can_issue;
  assign in_ready  = rnd_valid & can_issue;
  assign rnd_ready = in_valid & can_issue;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = fifo_q[rd_ptr_q];
  assign busy      = s1_valid_q | (count_q != 2'd0);

  // NOTE: always_comb assigns every output a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (!push && pop) begin
      count_d = count_q - 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge values of the others. The two FIFO entries are reset as well because
  // out_data shows entry 0 straight out of reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_valid_q <= 1'b0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      a_prev_q   <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      s1_valid_q <= fire;
      count_q    <= count_d;
      if (fire) begin
        a_prev_q <= in_a;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= g_out;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

`ifdef MSK_SEQ_ZEROIZE_EN
  // Unconsumed shares and randomness never reach the gadget logic.
  assign g_ina      = fire ? in_a : '0;
  assign g_inb      = fire ? in_b : '0;
  assign g_rnd      = fire ? rnd  : '0;
  assign g_ina_prev = s1_valid_q ? a_prev_q : '0;
`else
  assign g_ina      = in_a;
  assign g_inb      = in_b;
  assign g_rnd      = rnd;
  assign g_ina_prev = a_prev_q;
`endif

endmodule

// File: tb/tb_msk_and_hpc3_seq.sv
// Self-checking bench for msk_and_hpc3_seq (d=2, W=1) driving a behavioural HPC3-style
// gadget bank and scoring results against an unmasked transaction-level model.
module tb_msk_and_hpc3_seq;

  localparam int D  = 2;
  localparam int W  = 1;
  localparam int DW = W * D;
  localparam int RL = D * (D - 1);
  localparam int RW = W * RL;

  logic          clk = 1'b0;
  logic          nrst;
  logic          in_valid, in_ready, rnd_valid, rnd_ready, out_valid, out_ready, busy;
  logic [DW-1:0] in_a, in_b, g_ina, g_inb, g_ina_prev, g_out, out_data;
  logic [RW-1:0] rnd, g_rnd;

  always #5 clk = ~clk;

  msk_and_hpc3_seq #(.d(D), .W(W)) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd(rnd),
    .g_ina(g_ina), .g_inb(g_inb), .g_rnd(g_rnd), .g_ina_prev(g_ina_prev), .g_out(g_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  // Gadget bank: free-running registers, one cycle latency; the cross-domain partial
  // product is recombined with a_prev & Reg[r] so the shares XOR to a&b.
  logic [DW-1:0] inner_q;
  logic [RW-1:0] cross_q, rreg_q;

  function automatic int pidx(int i, int j);
    return i * (D - 1) + ((j < i) ? j : j - 1);
  endfunction

  always @(posedge clk) begin
    rreg_q <= g_rnd;
    for (int l = 0; l < W; l++) begin
      for (int i = 0; i < D; i++) begin
        inner_q[l*D+i] <= g_ina[l*D+i] & g_inb[l*D+i];
        for (int j = 0; j < D; j++) begin
          if (j != i) begin
            cross_q[l*RL+pidx(i, j)] <=
              g_ina[l*D+i] & (g_inb[l*D+j] ^ g_rnd[l*RL+pidx(i, j)]);
          end
        end
      end
    end
  end

  always_comb begin
    g_out = inner_q;
    for (int l = 0; l < W; l++) begin
      for (int i = 0; i < D; i++) begin
        for (int j = 0; j < D; j++) begin
          if (j != i) begin
            g_out[l*D+i] = g_out[l*D+i] ^ cross_q[l*RL+pidx(i, j)] ^
                           (g_ina_prev[l*D+i] & rreg_q[l*RL+pidx(i, j)]);
          end
        end
      end
    end
  end

  // Reference model: accepted transactions, unmasked result and the cycle they fired in.
  typedef struct {
    logic [W-1:0] res;
    int           cyc;
  } txn_t;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [RW-1:0] r;
    logic [W-1:0]  exp;
  } vec_t;

  txn_t pend[$];
  vec_t vecs[8];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic obs_fire;

  function automatic logic [W-1:0] unmask(logic [DW-1:0] x);
    logic [W-1:0] r = '0;
    for (int l = 0; l < W; l++)
      for (int s = 0; s < D; s++) r[l] = r[l] ^ x[l*D+s];
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Called in the drive window with inputs already applied: scores the cycle,
  // advances the model and moves to the next drive window.
  task automatic cycle();
    bit head_ready, pop, exp_rdy, fire;
    int occ;
    #1;
    head_ready = (pend.size() > 0) && (pend[0].cyc + 2 <= cyc);
    pop        = head_ready && out_ready;
    occ        = pend.size() - (pop ? 1 : 0);
    exp_rdy    = nrst && (occ < 2);
    fire       = in_valid && rnd_valid && exp_rdy;
    check("out_valid", 32'(out_valid), 32'(head_ready));
    if (head_ready) check("out_data", 32'(unmask(out_data)), 32'(pend[0].res));
    check("in_ready", 32'(in_ready), 32'(rnd_valid && exp_rdy));
    check("rnd_ready", 32'(rnd_ready), 32'(in_valid && exp_rdy));
    check("busy", 32'(busy), 32'(pend.size() > 0));
    obs_fire = in_valid & in_ready;
    if (pop) void'(pend.pop_front());
    if (fire) pend.push_back('{res: unmask(in_a) & unmask(in_b), cyc: cyc});
    if (pend.size() > 2) begin
      n_errors++;
      $display("FAIL overflow: %0d outstanding, limit 2", pend.size());
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive_rand();
    in_a = DW'($urandom);
    in_b = DW'($urandom);
    rnd  = RW'($urandom);
  endtask

  int fires;

  initial begin
    vecs[0] = '{a: 2'b01, b: 2'b10, r: 2'b10, exp: 1'b1};
    vecs[1] = '{a: 2'b11, b: 2'b01, r: 2'b01, exp: 1'b0};
    vecs[2] = '{a: 2'b10, b: 2'b10, r: 2'b11, exp: 1'b1};
    vecs[3] = '{a: 2'b00, b: 2'b11, r: 2'b10, exp: 1'b0};
    vecs[4] = '{a: 2'b01, b: 2'b00, r: 2'b01, exp: 1'b0};
    vecs[5] = '{a: 2'b10, b: 2'b01, r: 2'b00, exp: 1'b1};
    vecs[6] = '{a: 2'b11, b: 2'b11, r: 2'b11, exp: 1'b0};
    vecs[7] = '{a: 2'b01, b: 2'b01, r: 2'b11, exp: 1'b1};

    // Reset with valids high: both readies must stay low.
    nrst = 1'b0; in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b0;
    in_a = 2'b11; in_b = 2'b11; rnd = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", 32'(out_valid), 0);
    check("rst busy", 32'(busy), 0);
    check("rst in_ready", 32'(in_ready), 0);
    check("rst rnd_ready", 32'(rnd_ready), 0);
    check("rst out_data", 32'(out_data), 0);
    in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b1;
    nrst = 1'b1;
    @(posedge clk); #1;

    // Directed single operations from the table.
    for (int v = 0; v < 8; v++) begin
      in_a = vecs[v].a; in_b = vecs[v].b; rnd = vecs[v].r;
      in_valid = 1'b1; rnd_valid = 1'b1;
      #1;
      check("issue g_ina", 32'(g_ina), 32'(vecs[v].a));
      check("issue g_rnd", 32'(g_rnd), 32'(vecs[v].r));
      cycle();
      in_valid = 1'b0; rnd_valid = 1'b0;
      cycle();
      #1;
      check("table result", 32'(unmask(out_data)), 32'(vecs[v].exp));
      cycle();
      cycle();
    end

    // Back-to-back: eight consecutive fires, results stream out in order.
    fires = 0;
    for (int c = 0; c < 11; c++) begin
      in_valid = (c < 8); rnd_valid = (c < 8);
      drive_rand();
      cycle();
      fires += obs_fire;
    end
    check("b2b fires", 32'(fires), 8);

    // Backpressure: only two evaluations accepted while the consumer stalls.
    out_ready = 1'b0; in_valid = 1'b1; rnd_valid = 1'b1; fires = 0;
    for (int c = 0; c < 5; c++) begin
      drive_rand();
      cycle();
      fires += obs_fire;
    end
    check("bp fires", 32'(fires), 2);
    check("bp in_ready", 32'(in_ready), 0);
    check("bp rnd_ready", 32'(rnd_ready), 0);
    out_ready = 1'b1;
    #1;
    check("bp resume", 32'(in_ready), 1);
    cycle();
    in_valid = 1'b0; rnd_valid = 1'b0;
    repeat (4) cycle();

    // Randomness starvation.
    in_valid = 1'b1; rnd_valid = 1'b0;
    repeat (5) begin drive_rand(); cycle(); end
    rnd_valid = 1'b1;
    #1;
    check("starve release", 32'(in_ready), 1);
    cycle();
    in_valid = 1'b0; rnd_valid = 1'b0;
    repeat (3) cycle();

    // Reset mid-operation with one result buffered and one in flight.
    out_ready = 1'b0; in_valid = 1'b1; rnd_valid = 1'b1;
    drive_rand(); cycle();
    drive_rand(); cycle();
    in_valid = 1'b0; rnd_valid = 1'b0;
    nrst = 1'b0;
    #1;
    check("midrst out_valid", 32'(out_valid), 0);
    check("midrst busy", 32'(busy), 0);
    pend.delete();
    @(posedge clk); cyc++; #1;
    nrst = 1'b1; out_ready = 1'b1;
    repeat (4) cycle();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      rnd_valid = ($urandom_range(2) != 0);
      out_ready = $urandom_range(1);
      drive_rand();
      cycle();
    end
    in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();
    check("drained", 32'(pend.size()), 0);

    // Idle gadget inputs.
    in_a = 2'b11; in_b = 2'b10; rnd = 2'b11;
    #1;
`ifdef MSK_SEQ_ZEROIZE_EN
    check("idle g_ina", 32'(g_ina), 0);
    check("idle g_inb", 32'(g_inb), 0);
    check("idle g_rnd", 32'(g_rnd), 0);
    check("idle g_ina_prev", 32'(g_ina_prev), 0);
`else
    check("idle g_ina", 32'(g_ina), 32'(in_a));
    check("idle g_inb", 32'(g_inb), 32'(in_b));
    check("idle g_rnd", 32'(g_rnd), 32'(rnd));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
